countdown_timer: RTL

Enable-driven down-counter that loads a programmable `max`, steps toward zero on each enable, and emits a one-cycle `expire` pulse on reaching zero, then reloads (auto-reload) or stops (one-shot). It complements the wrapping up-counter: that block measures elapsed steps, this one schedules events, such as snake move ticks, food respawn delays and game-over hold time. It sits between the game tick source and the game-state controller.

---
 rtl/countdown_timer_pkg.sv | 5 +
 rtl/countdown_timer_en_divider.sv | 19 +
 rtl/countdown_timer.sv | 70 +++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared state encoding and default width for the countdown timer
package countdown_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} countdown_state_t;
  localparam int COUNTDOWN_WIDTH = 5;
endpackage

// File: rtl/countdown_timer_en_divider.sv
// en_divider: emits one step per PRESCALE qualified enables; clear restarts the phase
module en_divider #(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic step
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [CW-1:0] cnt_q;
  assign step = en && cnt_q == CW'(PRESCALE - 1);
  // count enables, wrapping to zero on the step or on any clear
  always_ff @(posedge clock) begin
    if (reset || clear || step) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: enable-driven down-counter with expire pulse, one-shot or auto-reload; COUNTDOWN_PRESCALE_EN adds an enable prescaler
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH    = COUNTDOWN_WIDTH,
  parameter int PRESCALE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             expire,
  output logic             busy,
  output logic             done
);
  countdown_state_t state_q;
  logic [WIDTH-1:0] count_q;
  logic expire_q, step, run, zero_hit;
  assign run = state_q == RUN;
  assign zero_hit = run && step && (count_q == WIDTH'(1) || (count_q == '0 && max == '0));
`ifdef COUNTDOWN_PRESCALE_EN
  en_divider #(.PRESCALE(PRESCALE)) u_div (
    .clock(clock),
    .reset(reset),
    .clear(stop || start || zero_hit),
    .en   (en && run),
    .step (step)
  );
`else
  assign step = en && (PRESCALE >= 1);
`endif
  // state, count and expire pulse with priority reset > stop > start > step
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        count_q <= '0;
      end else if (start) begin
        count_q  <= max;
        state_q  <= max == '0 ? DONE : RUN;
        expire_q <= max == '0;
      end else if (run && step) begin
        if (count_q > WIDTH'(1)) begin
          count_q <= count_q - 1'b1;
        end else if (count_q == WIDTH'(1)) begin
          count_q  <= '0;
          expire_q <= 1'b1;
          state_q  <= auto_reload ? RUN : DONE;
        end else begin
          count_q  <= max;
          expire_q <= max == '0;
          state_q  <= max == '0 ? DONE : RUN;
        end
      end
    end
  end
  assign count  = count_q;
  assign expire = expire_q;
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
endmodule
